// File: rtl/reg_writeback_scheduler.sv
// Write-port scheduler for the 8-entry register file: round-robin ALU/load arbitration,
// a registered write stage and a pending-write scoreboard for decode hazard stalls.
module reg_writeback_scheduler #(
  parameter int BITS     = 16,
  parameter int SEL_BITS = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_issue_valid,
  input  logic [SEL_BITS-1:0] i_issue_rd,
  output logic                o_issue_ready,
  input  logic [SEL_BITS-1:0] i_src1_sel,
  input  logic [SEL_BITS-1:0] i_src2_sel,
  output logic                o_src1_busy,
  output logic                o_src2_busy,
  input  logic                i_alu_valid,
  input  logic [SEL_BITS-1:0] i_alu_rd,
  input  logic [BITS-1:0]     i_alu_data,
  output logic                o_alu_ready,
  input  logic                i_mem_valid,
  input  logic [SEL_BITS-1:0] i_mem_rd,
  input  logic [BITS-1:0]     i_mem_data,
  output logic                o_mem_ready,
  output logic [SEL_BITS-1:0] o_wr_sel,
  output logic [BITS-1:0]     o_wr_data,
  output logic                o_wr_dis,
  output logic [(1<<SEL_BITS)-1:0] o_busy,
  output logic                o_err
);

  localparam int NREGS = 1 << SEL_BITS;

  // state        | meaning
  // LAST_ALU     | ALU won the most recent transfer; MEM wins next contention
  // LAST_MEM     | MEM won the most recent transfer (reset); ALU wins next contention
  typedef enum logic {LAST_ALU = 1'b0, LAST_MEM = 1'b1} grant_state_t;

  grant_state_t r_state;
  grant_state_t w_next_state;

  logic                r_wr_dis;
  logic [SEL_BITS-1:0] r_wr_sel;
  logic [BITS-1:0]     r_wr_data;
  logic [NREGS-1:0]    r_busy;
  logic                r_err;

  logic                w_grant_alu;
  logic                w_grant_mem;
  logic                w_xfer;
  logic [SEL_BITS-1:0] w_win_rd;
  logic [BITS-1:0]     w_win_data;
  logic                w_issue_ready;
  logic                w_issue_fire;
  logic                w_commit;
  logic                w_commit_stray;
  logic [NREGS-1:0]    w_busy_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= LAST_MEM;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_grant_alu)      w_next_state = LAST_ALU;
    else if (w_grant_mem) w_next_state = LAST_MEM;
  end

  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_mem = 1'b0;
    case (r_state)
      LAST_MEM: begin
        w_grant_alu = i_alu_valid;
        w_grant_mem = i_mem_valid & ~i_alu_valid;
      end
      LAST_ALU: begin
        w_grant_mem = i_mem_valid;
        w_grant_alu = i_alu_valid & ~i_mem_valid;
      end
      default: begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
      end
    endcase
  end

  assign w_xfer     = w_grant_alu | w_grant_mem;
  assign w_win_rd   = w_grant_alu ? i_alu_rd   : i_mem_rd;
  assign w_win_data = w_grant_alu ? i_alu_data : i_mem_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_dis  <= 1'b1;
      r_wr_sel  <= '0;
      r_wr_data <= '0;
    end else if (w_xfer) begin
      r_wr_dis  <= 1'b0;
      r_wr_sel  <= w_win_rd;
      r_wr_data <= w_win_data;
    end else begin
      r_wr_dis  <= 1'b1;
    end
  end

  // Issue sees only the registered scoreboard, so a commit this cycle does not free its register yet.
  assign w_issue_ready  = ~r_busy[i_issue_rd];
  assign w_issue_fire   = i_issue_valid & w_issue_ready;
  assign w_commit       = ~r_wr_dis;
  assign w_commit_stray = w_commit & ~r_busy[r_wr_sel];

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_commit)     w_busy_nxt[r_wr_sel]   = 1'b0;
    if (w_issue_fire) w_busy_nxt[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_commit_stray) r_err <= 1'b1;
    end
  end

  assign o_issue_ready = w_issue_ready;
  assign o_src1_busy   = r_busy[i_src1_sel];
  assign o_src2_busy   = r_busy[i_src2_sel];
  assign o_alu_ready   = w_grant_alu;
  assign o_mem_ready   = w_grant_mem;
  assign o_wr_sel      = r_wr_sel;
  assign o_wr_data     = r_wr_data;
  assign o_wr_dis      = r_wr_dis;
  assign o_busy        = r_busy;
  assign o_err         = r_err;

endmodule

// File: doc/reg_writeback_scheduler.md
Name: reg_writeback_scheduler

Overview:
Owns the 16-bit x 8 register file's single write port: drives its write-select (sel0), data input and writeDisable.
Arbitrates round-robin between two write-back requesters (ALU result, memory load) using valid/ready handshakes, with a one-stage registered output.
Keeps an 8-bit pending-write scoreboard, set at instruction issue and cleared at write commit, so the decode stage can stall on RAW/WAW hazards.

Parameters:
BITS, 16, data width of write-back values and of the register file
SEL_BITS, 3, register address width (8 registers); fixed at 3 for this register file

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
issue_valid  in  1  decode wants to reserve destination issue_rd
issue_rd  in  3  destination register to mark pending
issue_ready  out  1  reservation accepted this cycle
src1_sel  in  3  decode source operand 1 register
src2_sel  in  3  decode source operand 2 register
src1_busy  out  1  busy[src1_sel], combinational
src2_busy  out  1  busy[src2_sel], combinational
alu_valid  in  1  ALU write-back request
alu_rd  in  3  ALU destination
alu_data  in  BITS  ALU result
alu_ready  out  1  ALU request accepted
mem_valid  in  1  load write-back request
mem_rd  in  3  load destination
mem_data  in  BITS  load data
mem_ready  out  1  load request accepted
wr_sel  out  3  to register file sel0
wr_data  out  BITS  to register file in
wr_dis  out  1  to register file writeDisable (1 = no write)
busy  out  8  scoreboard vector, bit n = register n has a pending write
err  out  1  sticky: a write committed to a non-pending register

Behaviour:
- Reset (async, immediate): busy=0, wr_dis=1, wr_sel=0, wr_data=0, err=0, last_grant=MEM (ALU wins first contention). Handshakes are combinational: after reset issue_ready=1 and no ready asserts without a valid.
- Handshake: a requester holds valid/rd/data stable until it sees ready=1. Transfer occurs on the edge where valid&ready=1.
- Arbitration (combinational, cycle N):
  - Only one valid: grant it.
  - Both valid: grant the side opposite last_grant.
  - alu_ready=grant_alu, mem_ready=grant_mem. Never both 1; 0 when no valid.
  - last_grant updates on every transfer.
- Output stage:
  - Transfer at end of cycle N: during cycle N+1, wr_dis=0 and wr_sel/wr_data hold the winner's rd/data. The register file writes at end of N+1.
  - No transfer in N: wr_dis=1 in N+1; wr_sel/wr_data hold their previous values.
  - Throughput is one write per cycle; back-to-back transfers keep wr_dis=0 continuously.
- Scoreboard:
  - Set: at edge where issue_valid&issue_ready, set busy[issue_rd]. issue_ready = ~busy[issue_rd]; no bypass.
  - Clear: at the edge ending a cycle with wr_dis=0, clear busy[wr_sel], the same edge the register file captures. The new value and busy=0 are both visible from cycle N+2.
  - Same-edge set and clear: always different registers, since a committing register is busy so issue to it is refused. Both take effect.
  - Commit when busy[wr_sel]=0: the write still happens, err sets and stays 1 until rst.
- Every register 0..7 is general purpose; none is hardwired.
- Reset mid-operation: a pending output write is dropped (wr_dis=1 at once); scoreboard cleared; requesters must re-present.
- No combinational path from wr_* back to any ready or busy output except through registers.

Test Plan:
1. Assert rst mid-run with wr_dis=0 -> wr_dis=1, busy=8'h00, err=0 asynchronously; after release, issue_ready=1, alu_ready=mem_ready=0.
2. Issue rd=3; next cycle src1_sel=3; then alu_valid rd=3 data=16'hBEEF:
   - After issue, busy=8'h08 and src1_busy=1.
   - alu_ready=1 in cycle N; cycle N+1 wr_dis=0, wr_sel=3, wr_data=BEEF.
   - Cycle N+2 busy=8'h00, src1_busy=0, register 3 reads BEEF.
3. Issue rd=1 and rd=2; alu_valid (rd=1, 16'h1111) and mem_valid (rd=2, 16'h2222) held from same cycle -> grants ALU then MEM on consecutive cycles, wr_dis=0 both cycles, busy returns to 8'h00, err=0.
4. Both requesters continuously valid for 6 cycles, rd pre-issued -> grant sequence ALU,MEM,ALU,MEM,ALU,MEM; never both ready.
5. busy[4]=1, write to 4 committing while issue_rd=4 -> issue_ready=0. Same cycle issue_rd=5 -> issue_ready=1; next cycle busy[4]=0, busy[5]=1.
6. mem write to rd=6 with busy[6]=0 -> write performed (wr_sel=6, wr_dis=0), err=1 and stays 1 across later clean writes until rst.
